// File: rtl/button_pkg.sv
// button_pkg: shared types for the button event block.
// Holds the FSM state encoding and the press counter width.
package button_pkg;

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        HELD     = 2'd2,
        LONG     = 2'd3
    } btn_state_t;

    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/button_events.sv
// button_events: turns a debounced button level into single-cycle
// press / release / long-press / auto-repeat events, plus a held
// level and a wrapping 8-bit press counter. All outputs registered.
// Optional feature: define BUTTON_REPEAT_EN to enable auto-repeat;
// otherwise repeat_pulse is tied to 0.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   clean          debounced level, 1 = pressed
//   press          pulse on accepted press
//   release_pulse  pulse on release of an accepted press
//   long_press     pulse when the hold reaches LONG_CYCLES
//   repeat_pulse   periodic pulse after long_press
//   held           1 while the press is held (HELD or LONG)
//   press_cnt      count of accepted presses, wraps
// ("release" and "repeat" are reserved words, hence the _pulse names.)
module button_events
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_BITS      = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clean,
    output logic                   press,
    output logic                   release_pulse,
    output logic                   long_press,
    output logic                   repeat_pulse,
    output logic                   held,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam logic [CNT_BITS-1:0] LONG_LAST =
        CNT_BITS'(LONG_CYCLES - 1);

    btn_state_t             state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   held_q, held_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_BITS-1:0] REP_LAST =
        CNT_BITS'(REPEAT_CYCLES - 1);

    logic repeat_q, repeat_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        press_cnt_d = press_cnt_q;
`ifdef BUTTON_REPEAT_EN
        repeat_d    = 1'b0;
`endif
        unique case (state_q)
            // A button already down at reset must be let go first.
            WAIT_REL: begin
                cnt_d = '0;
                if (!clean) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (clean) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            // Release is tested first so it wins over long_press.
            HELD: begin
                if (!clean) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!clean) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef BUTTON_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == LONG);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_REL;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign held          = held_q;
    assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed plus random stimulus for button_events,
// checked every cycle against an event-timing model of the button.
module tb_button_events;

    localparam int LONG = 8;
    localparam int REP  = 4;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       clean;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: armed = seen low since reset, pressed = press accepted,
    // age = edges since press pulse.
    bit         m_armed;
    bit         m_pressed;
    int         m_age;
    logic [7:0] m_cnt;
    logic       e_press, e_rel, e_long, e_rep;

    int n_press_seen, n_rel_seen;

    button_events #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP),
        .CNT_BITS     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clean        (clean),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_cnt    (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [12:0] obs,
                         input logic [12:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed   = 1'b0;
        m_pressed = 1'b0;
        m_age     = 0;
        m_cnt     = 8'd0;
        e_press   = 1'b0;
        e_rel     = 1'b0;
        e_long    = 1'b0;
        e_rep     = 1'b0;
    endtask

    task automatic model_edge(input logic c);
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (!m_armed) begin
            if (!c) m_armed = 1'b1;
        end else if (!m_pressed) begin
            if (c) begin
                m_pressed = 1'b1;
                m_age     = 0;
                e_press   = 1'b1;
                m_cnt     = m_cnt + 8'd1;
            end
        end else begin
            m_age++;
            if (!c) begin
                e_rel     = 1'b1;
                m_pressed = 1'b0;
            end else if (m_age == LONG) begin
                e_long = 1'b1;
            end else if (REP_EN && m_age > LONG
                         && (m_age - LONG) % REP == 0) begin
                e_rep = 1'b1;
            end
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {press, release_pulse, long_press,
                repeat_pulse, held, press_cnt};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_press, e_rel, e_long, e_rep, m_pressed, m_cnt};
    endfunction

    task automatic step(input string tag, input logic c);
        clean = c;
        @(posedge clk);
        model_edge(c);
        #1;
        check(tag, obs_vec(), exp_vec());
        if (press) n_press_seen++;
        if (release_pulse) n_rel_seen++;
    endtask

    task automatic run(input string tag, input logic c, input int n);
        for (int i = 0; i < n; i++) step(tag, c);
    endtask

    // Asserted mid-cycle so the clear must be asynchronous.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check(tag, obs_vec(), 13'd0);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        clean = 1'b1;
        #1;
        check("reset_val", obs_vec(), 13'd0);
        run("in_reset", 1'b1, 2);

        // 1: held through reset release -> no pulses
        reset = 1'b1;
        run("t1_hold", 1'b1, 5);
        run("t1_low", 1'b0, 3);

        // 2: short press
        run("t2_high", 1'b1, 3);
        run("t2_low", 1'b0, 3);
        check("t2_cnt", {5'd0, press_cnt}, 13'd1);

        // 3: long hold with repeats
        run("t3_high", 1'b1, 20);
        run("t3_low", 1'b0, 3);

        // 4: release on the long_press edge
        run("t4_high", 1'b1, LONG);
        run("t4_low", 1'b0, 3);

        // 5: reset mid-LONG with clean still high
        run("t5_high", 1'b1, 12);
        async_reset("t5_async");
        run("t5_inrst", 1'b1, 2);
        reset = 1'b1;
        run("t5_after", 1'b1, 6);
        run("t5_low", 1'b0, 2);
        run("t5_fresh", 1'b1, 2);
        run("t5_fresh_lo", 1'b0, 2);

        // 6: 256 presses from a cleared counter
        async_reset("t6_rst");
        run("t6_inrst", 1'b0, 2);
        reset = 1'b1;
        run("t6_arm", 1'b0, 1);
        n_press_seen = 0;
        n_rel_seen   = 0;
        for (int i = 0; i < 256; i++) begin
            step("t6_hi", 1'b1);
            step("t6_lo", 1'b0);
        end
        check("t6_wrap", {5'd0, press_cnt}, 13'd0);
        check("t6_npress", 13'(n_press_seen), 13'd256);
        check("t6_nrel", 13'(n_rel_seen), 13'd256);

        // 7: random runs with occasional async resets
        for (int k = 0; k < 300; k++) begin
            run("rand", 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 16)));
            if ($urandom_range(0, 24) == 0) begin
                async_reset("rand_rst");
                run("rand_inrst", 1'($urandom_range(0, 1)), 1);
                reset = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Converts the debounced, clock-synchronous button level from the debouncer into discrete single-cycle events for the control logic: press, release, long-press and optional auto-repeat. It sits directly downstream of the debouncer, on its `clean` output, and upstream of any menu or mode FSM. It also provides a registered held level and a wrapping press counter.

## Interface
- `LONG_CYCLES`, default 50_000_000: cycles the button must stay held after `press` before `long_press` fires; must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of `repeat` pulses after `long_press`; must be ≥ 2.
- `CNT_BITS`, default 26: hold-counter width; must hold max(`LONG_CYCLES`, `REPEAT_CYCLES`) − 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clean`  in  1  debounced button level, synchronous to `clk`, 1 = pressed.
- `press`  out  1  one-cycle pulse on accepted press.
- `release`  out  1  one-cycle pulse on release of an accepted press.
- `long_press`  out  1  one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat`  out  1  one-cycle auto-repeat pulse; constant 0 when the feature is compiled out.
- `held`  out  1  level, 1 while in `HELD` or `LONG`.
- `press_cnt`  out  8  count of accepted presses; wraps 255 → 0.

## Operation
- **Reset values.** While `reset` is low:
  - state = `WAIT_REL`
  - hold counter = 0
  - all outputs = 0, including `press_cnt`
- **`WAIT_REL`** (reset state):
  - Ignores `clean` = 1. A button held through reset never produces `press`.
  - `clean` = 0 → `IDLE`. No pulse.
- **`IDLE`:**
  - `clean` = 1 → `HELD`.
  - Counter cleared to 0.
  - `press` = 1 for one cycle; `press_cnt` += 1.
- **`HELD`:**
  - Counter += 1 each cycle.
  - `clean` = 0 → `IDLE`; `release` = 1 for one cycle.
  - Else if counter == `LONG_CYCLES` − 1 → `LONG`; `long_press` = 1 for one cycle; counter cleared.
  - Release has priority when both conditions are true on the same edge: no `long_press` is issued.
- **`LONG`:**
  - `clean` = 0 → `IDLE`; `release` = 1 for one cycle.
  - With repeat enabled: counter += 1; at `REPEAT_CYCLES` − 1, `repeat` = 1 for one cycle and counter cleared.
  - Release beats repeat on the same edge.
- **Pulse rules.**
  - At most one of `press`/`release`/`long_press`/`repeat` is high in any cycle.
  - Every `press` is followed by exactly one `release` unless `reset` intervenes.
- **Counter width.** The counter is unsigned, `CNT_BITS` wide, and never wraps in normal operation; it is always cleared on a state change.
- **Reset mid-hold.** Asserting `reset` mid-hold drops all outputs immediately (asynchronously). After release of `reset` the block is in `WAIT_REL`, so there is no spurious `press` or `release`.

## Timing
- All outputs are registered.
- Latency: `clean` sampled high at edge k → `press` high in the cycle following edge k; `held` rises on the same edge.
- `long_press` rises exactly `LONG_CYCLES` edges after `press` rose, if `clean` stays 1.
- The first `repeat` rises `REPEAT_CYCLES` edges after `long_press`, then repeats every `REPEAT_CYCLES` edges.
- `release` rises one edge after `clean` is sampled low; `held` falls on the same edge.
- One-cycle glitches on `clean` are not filtered here; a 1-cycle high produces `press` followed by `release` on the next edge.

## Configuration
- `BUTTON_REPEAT_EN` defined:
  - `LONG` runs the repeat counter and emits periodic `repeat` pulses.
- Not defined:
  - `repeat` is tied to 0.
  - The counter holds at 0 in `LONG`.
  - `LONG` only waits for release.
  - `REPEAT_CYCLES` is unused.

## Structure
- Shared package `button_pkg`:
  - `btn_state_t` enum: `WAIT_REL`, `IDLE`, `HELD`, `LONG`, 2-bit encoding.
  - `localparam PRESS_CNT_W` = 8.
- Single module. The FSM and counter are too tightly coupled for a useful sub-module split.

## Test plan
Parameters for all scenarios: `LONG_CYCLES` = 8, `REPEAT_CYCLES` = 4.
1. Hold `clean` = 1 across `reset` release, drop it 5 cycles later → no pulses at all, state reaches `IDLE`, `press_cnt` = 0.
2. `clean` high for 3 cycles → `press` 1 cycle after rise, `release` 1 cycle after fall, no `long_press`, `press_cnt` = 1.
3. `clean` high for 20 cycles with `BUTTON_REPEAT_EN` defined:
   - `long_press` 8 cycles after `press`.
   - `repeat` 4 and 8 cycles after `long_press`.
   - `release` 1 cycle after fall.
   - Without the macro: same sequence but no `repeat`.
4. `clean` falls on the exact edge the counter reaches 7 → `release` only, no `long_press`.
5. Assert `reset` mid-`LONG` → all outputs 0 immediately. After release of `reset` with `clean` still high: no pulse until a fresh press.
6. 256 short presses → `press_cnt` wraps to 0, and each press gives exactly one `press`/`release` pair.
